// File: rtl/comp_sweep_pkg.sv
// Shared types and defaults for the comparator sweep sequencer.
// Build option COMP_SWEEP_ABORT_EN adds an abort input to the control shell.
package comp_sweep_pkg;

    localparam int unsigned DEF_WIDTH = 4;
    localparam logic [DEF_WIDTH-1:0] DEF_MATCH = 4'b0101;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } sweep_state_e;

    // Match counter needs one extra bit to hold the full 2^WIDTH code count.
    function automatic int unsigned cnt_width(input int unsigned width);
        return width + 1;
    endfunction

endpackage

// File: rtl/comp_sweep_ctrl_if.sv
// Control/result bundle between a sweep requester (master) and comp_sweep_ctrl (slave).
// Build option COMP_SWEEP_ABORT_EN adds the abort request line.
interface comp_sweep_ctrl_if
    import comp_sweep_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
);

    logic                 start;
`ifdef COMP_SWEEP_ABORT_EN
    logic                 abort;
`endif
    logic                 busy;
    logic                 done;
    logic [WIDTH-1:0]     a_out;
    logic                 e_out;
    logic                 found;
    logic [WIDTH-1:0]     first_idx;
    logic [WIDTH:0]       match_cnt;

`ifdef COMP_SWEEP_ABORT_EN
    modport master (
        output start, abort,
        input  busy, done, a_out, e_out, found, first_idx, match_cnt
    );
    modport slave (
        input  start, abort,
        output busy, done, a_out, e_out, found, first_idx, match_cnt
    );
`else
    modport master (
        output start,
        input  busy, done, a_out, e_out, found, first_idx, match_cnt
    );
    modport slave (
        input  start,
        output busy, done, a_out, e_out, found, first_idx, match_cnt
    );
`endif

endinterface

// File: rtl/comp_sweep_ctrl_comp_const.sv
// Constant-match comparator: e is high when operand a equals MATCH_VALUE.
module comp_const
    import comp_sweep_pkg::*;
#(
    parameter int unsigned          WIDTH       = DEF_WIDTH,
    parameter logic [WIDTH-1:0]     MATCH_VALUE = WIDTH'(DEF_MATCH)
) (
    input  logic [WIDTH-1:0] a,
    output logic             e
);

    assign e = (a == MATCH_VALUE);

endmodule

// File: rtl/comp_sweep_ctrl.sv
// Sweeps an operand through every code against comp_const and records found/first/count.
// Build option COMP_SWEEP_ABORT_EN adds bus.abort to cancel a sweep without a done pulse.
module comp_sweep_ctrl
    import comp_sweep_pkg::*;
#(
    parameter int unsigned          WIDTH       = DEF_WIDTH,
    parameter logic [WIDTH-1:0]     MATCH_VALUE = WIDTH'(DEF_MATCH)
) (
    input  logic              clk,
    input  logic              rst_n,
    comp_sweep_ctrl_if.slave  bus
);

    localparam int unsigned      CW     = cnt_width(WIDTH);
    localparam logic [WIDTH-1:0] A_LAST = {WIDTH{1'b1}};

    sweep_state_e     state;
    logic             busy_q;
    logic             done_q;
    logic             found_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] first_q;
    logic [CW-1:0]    cnt_q;
    logic             e_c;
    logic             abort_c;

    comp_const #(
        .WIDTH       (WIDTH),
        .MATCH_VALUE (MATCH_VALUE)
    ) u_comp (
        .a (a_q),
        .e (e_c)
    );

`ifdef COMP_SWEEP_ABORT_EN
    assign abort_c = bus.abort;
`else
    assign abort_c = 1'b0;
`endif

    // Sequencer: abort outranks the final-code completion, results survive until next start.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            found_q <= 1'b0;
            a_q     <= '0;
            first_q <= '0;
            cnt_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state   <= SWEEP;
                        busy_q  <= 1'b1;
                        a_q     <= '0;
                        found_q <= 1'b0;
                        first_q <= '0;
                        cnt_q   <= '0;
                    end
                end
                SWEEP: begin
                    if (abort_c) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end else begin
                        if (e_c) begin
                            cnt_q <= cnt_q + CW'(1);
                            if (!found_q) begin
                                found_q <= 1'b1;
                                first_q <= a_q;
                            end
                        end
                        if (a_q == A_LAST) begin
                            state  <= DONE;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                        end else begin
                            a_q <= a_q + WIDTH'(1);
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.a_out     = a_q;
    assign bus.e_out     = e_c;
    assign bus.found     = found_q;
    assign bus.first_idx = first_q;
    assign bus.match_cnt = cnt_q;

endmodule

// File: tb/tb_comp_sweep_ctrl.sv
// Self-checking bench for comp_sweep_ctrl: default instance plus two alternate parameterisations.
module tb_comp_sweep_ctrl;
    import comp_sweep_pkg::*;

    localparam int N = 16;
    localparam int M = 5;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    comp_sweep_ctrl_if #(.WIDTH(4)) bus   ();
    comp_sweep_ctrl_if #(.WIDTH(4)) bus_f ();
    comp_sweep_ctrl_if #(.WIDTH(3)) bus_3 ();

    comp_sweep_ctrl #(.WIDTH(4), .MATCH_VALUE(4'd5)) u_dut (
        .clk (clk), .rst_n (rst_n), .bus (bus)
    );
    comp_sweep_ctrl #(.WIDTH(4), .MATCH_VALUE(4'b1111)) u_dut_f (
        .clk (clk), .rst_n (rst_n), .bus (bus_f)
    );
    comp_sweep_ctrl #(.WIDTH(3), .MATCH_VALUE(3'b000)) u_dut_3 (
        .clk (clk), .rst_n (rst_n), .bus (bus_3)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [16:0] obs;
    assign obs = {bus.busy, bus.done, bus.a_out, bus.e_out, bus.found, bus.first_idx, bus.match_cnt};

    logic [3:0] hold_a;
    logic       hold_f;
    logic [3:0] hold_fi;
    logic [4:0] hold_c;

    // Expected observation vector; e_out follows directly from the operand.
    function automatic logic [16:0] mk(input logic b, input logic d, input logic [3:0] a,
                                       input logic f, input logic [3:0] fi, input logic [4:0] c);
        return {b, d, a, (a == 4'(M)), f, fi, c};
    endfunction

    // Matches among codes 0..upto-1.
    function automatic int exp_cnt(input int upto);
        int n = 0;
        for (int c = 0; c < upto; c++) if (c == M) n++;
        return n;
    endfunction

    function automatic int exp_first(input int upto);
        for (int c = 0; c < upto; c++) if (c == M) return c;
        return 0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.start = 1'b0; bus_f.start = 1'b0; bus_3.start = 1'b0;
`ifdef COMP_SWEEP_ABORT_EN
        bus.abort = 1'b0; bus_f.abort = 1'b0; bus_3.abort = 1'b0;
`endif
        tick();
        tick();
        n_checks++;
        if (obs !== mk(0, 0, 4'd0, 0, 4'd0, 5'd0)) begin
            n_fail++; $display("FAIL reset_held got=%h exp=%h", obs, mk(0, 0, 4'd0, 0, 4'd0, 5'd0));
        end
        rst_n = 1'b1;
        tick();
        n_checks++;
        if (obs !== mk(0, 0, 4'd0, 0, 4'd0, 5'd0)) begin
            n_fail++; $display("FAIL reset_release got=%h exp=%h", obs, mk(0, 0, 4'd0, 0, 4'd0, 5'd0));
        end
        n_checks++;
        if ({bus_f.busy, bus_f.done, bus_f.a_out, bus_f.e_out, bus_f.found, bus_f.match_cnt} !== 12'h000) begin
            n_fail++; $display("FAIL reset_alt_f got busy=%b done=%b a=%h e=%b cnt=%0d exp all 0",
                               bus_f.busy, bus_f.done, bus_f.a_out, bus_f.e_out, bus_f.match_cnt);
        end
        n_checks++;
        if ({bus_3.busy, bus_3.done, bus_3.a_out, bus_3.e_out, bus_3.found, bus_3.match_cnt} !== 10'b00_000_1_0_0000) begin
            n_fail++; $display("FAIL reset_alt_3 got busy=%b done=%b a=%h e=%b cnt=%0d exp e=1 rest 0",
                               bus_3.busy, bus_3.done, bus_3.a_out, bus_3.e_out, bus_3.match_cnt);
        end
    endtask

    task automatic test_default_sweep();
        logic [16:0] exp;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < N; i++) begin
            exp = mk(1, 0, 4'(i), exp_cnt(i) > 0, 4'(exp_first(i)), 5'(exp_cnt(i)));
            n_checks++;
            if (obs !== exp) begin
                n_fail++; $display("FAIL sweep cyc=%0d got=%h exp=%h", i, obs, exp);
            end
            tick();
        end
        exp = mk(0, 1, 4'd15, 1, 4'(M), 5'd1);
        n_checks++;
        if (obs !== exp) begin
            n_fail++; $display("FAIL sweep_done got=%h exp=%h", obs, exp);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            exp = mk(0, 0, 4'd15, 1, 4'(M), 5'd1);
            n_checks++;
            if (obs !== exp) begin
                n_fail++; $display("FAIL sweep_hold cyc=%0d got=%h exp=%h", i, obs, exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [16:0] exp;
        int ndone;
        bus.start = 1'b1;
        tick();
        for (int i = 0; i < N; i++) begin
            exp = mk(1, 0, 4'(i), exp_cnt(i) > 0, 4'(exp_first(i)), 5'(exp_cnt(i)));
            n_checks++;
            if (obs !== exp) begin
                n_fail++; $display("FAIL b2b_sweep cyc=%0d got=%h exp=%h", i, obs, exp);
            end
            tick();
        end
        exp = mk(0, 1, 4'd15, 1, 4'(M), 5'd1);
        n_checks++;
        if (obs !== exp) begin
            n_fail++; $display("FAIL b2b_done got=%h exp=%h", obs, exp);
        end
        tick();
        exp = mk(0, 0, 4'd15, 1, 4'(M), 5'd1);
        n_checks++;
        if (obs !== exp) begin
            n_fail++; $display("FAIL b2b_idle_gap got=%h exp=%h", obs, exp);
        end
        tick();
        bus.start = 1'b0;
        exp = mk(1, 0, 4'd0, 0, 4'd0, 5'd0);
        n_checks++;
        if (obs !== exp) begin
            n_fail++; $display("FAIL b2b_restart got=%h exp=%h", obs, exp);
        end
        ndone = 0;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (bus.done === 1'b1) begin
                ndone++;
                n_checks++;
                if (c != N) begin
                    n_fail++; $display("FAIL b2b_done_cycle got=%0d exp=%0d", c, N);
                end
            end
        end
        n_checks++;
        if (ndone != 1) begin
            n_fail++; $display("FAIL b2b_done_count got=%0d exp=1", ndone);
        end
    endtask

    task automatic test_reset_mid();
        logic [16:0] exp;
        int ndone;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        n_checks++;
        if (bus.a_out !== 4'd8) begin
            n_fail++; $display("FAIL rstmid_pos got=%0d exp=8", bus.a_out);
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        exp = mk(0, 0, 4'd0, 0, 4'd0, 5'd0);
        n_checks++;
        if (obs !== exp) begin
            n_fail++; $display("FAIL rstmid_clear got=%h exp=%h", obs, exp);
        end
        ndone = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) ndone++;
        end
        n_checks++;
        if (ndone != 0) begin
            n_fail++; $display("FAIL rstmid_no_done got=%0d active cycles exp=0", ndone);
        end
        hold_a = 4'd0; hold_f = 1'b0; hold_fi = 4'd0; hold_c = 5'd0;
    endtask

    task automatic test_random();
        logic [16:0] exp;
        int gap;
        int rst_at;
        bit cut;
        for (int it = 0; it < 12; it++) begin
            bus.start = 1'b0;
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                exp = mk(0, 0, hold_a, hold_f, hold_fi, hold_c);
                n_checks++;
                if (obs !== exp) begin
                    n_fail++; $display("FAIL rand_idle it=%0d got=%h exp=%h", it, obs, exp);
                end
                tick();
            end
            rst_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, N - 1)) : -1;
            cut = 1'b0;
            bus.start = 1'b1;
            tick();
            for (int i = 0; i < N; i++) begin
                if (!cut) begin
                    exp = mk(1, 0, 4'(i), exp_cnt(i) > 0, 4'(exp_first(i)), 5'(exp_cnt(i)));
                    n_checks++;
                    if (obs !== exp) begin
                        n_fail++; $display("FAIL rand_sweep it=%0d cyc=%0d got=%h exp=%h", it, i, obs, exp);
                    end
                    bus.start = 1'($urandom_range(0, 1));
                    if (i == rst_at) begin
                        rst_n = 1'b0;
                        cut = 1'b1;
                    end
                    tick();
                    rst_n = 1'b1;
                end
            end
            if (cut) begin
                hold_a = 4'd0; hold_f = 1'b0; hold_fi = 4'd0; hold_c = 5'd0;
            end else begin
                exp = mk(0, 1, 4'd15, 1, 4'(M), 5'(exp_cnt(N)));
                n_checks++;
                if (obs !== exp) begin
                    n_fail++; $display("FAIL rand_done it=%0d got=%h exp=%h", it, obs, exp);
                end
                bus.start = 1'b0;
                tick();
                hold_a = 4'd15; hold_f = 1'b1; hold_fi = 4'(M); hold_c = 5'(exp_cnt(N));
            end
            exp = mk(0, 0, hold_a, hold_f, hold_fi, hold_c);
            n_checks++;
            if (obs !== exp) begin
                n_fail++; $display("FAIL rand_end it=%0d cut=%0d got=%h exp=%h", it, cut, obs, exp);
            end
        end
        bus.start = 1'b0;
    endtask

    task automatic test_alt_params();
        int busy_f, busy_3, done_f, done_3, ndone_f, ndone_3, hit_f, hit_3, nhit_f, nhit_3;
        busy_f = 0; busy_3 = 0; done_f = -1; done_3 = -1; ndone_f = 0; ndone_3 = 0;
        hit_f = -1; hit_3 = -1; nhit_f = 0; nhit_3 = 0;
        bus_f.start = 1'b1; bus_3.start = 1'b1;
        tick();
        bus_f.start = 1'b0; bus_3.start = 1'b0;
        for (int c = 0; c < 30; c++) begin
            if (bus_f.busy === 1'b1) busy_f++;
            if (bus_3.busy === 1'b1) busy_3++;
            if (bus_f.done === 1'b1) begin ndone_f++; done_f = c; end
            if (bus_3.done === 1'b1) begin ndone_3++; done_3 = c; end
            if (bus_f.busy === 1'b1 && bus_f.e_out === 1'b1) begin nhit_f++; hit_f = c; end
            if (bus_3.busy === 1'b1 && bus_3.e_out === 1'b1) begin nhit_3++; hit_3 = c; end
            tick();
        end
        n_checks++;
        if (busy_f != 16 || ndone_f != 1 || done_f != 16 || nhit_f != 1 || done_f != hit_f + 1) begin
            n_fail++; $display("FAIL alt_f_timing got busy=%0d ndone=%0d done_at=%0d hits=%0d hit_at=%0d exp 16/1/16/1/15",
                               busy_f, ndone_f, done_f, nhit_f, hit_f);
        end
        n_checks++;
        if ({bus_f.found, bus_f.first_idx, bus_f.match_cnt, bus_f.a_out} !== {1'b1, 4'd15, 5'd1, 4'd15}) begin
            n_fail++; $display("FAIL alt_f_result got found=%b first=%0d cnt=%0d a=%0d exp 1/15/1/15",
                               bus_f.found, bus_f.first_idx, bus_f.match_cnt, bus_f.a_out);
        end
        n_checks++;
        if (busy_3 != 8 || ndone_3 != 1 || done_3 != 8 || nhit_3 != 1 || hit_3 != 0) begin
            n_fail++; $display("FAIL alt_3_timing got busy=%0d ndone=%0d done_at=%0d hits=%0d hit_at=%0d exp 8/1/8/1/0",
                               busy_3, ndone_3, done_3, nhit_3, hit_3);
        end
        n_checks++;
        if ({bus_3.found, bus_3.first_idx, bus_3.match_cnt, bus_3.a_out} !== {1'b1, 3'd0, 4'd1, 3'd7}) begin
            n_fail++; $display("FAIL alt_3_result got found=%b first=%0d cnt=%0d a=%0d exp 1/0/1/7",
                               bus_3.found, bus_3.first_idx, bus_3.match_cnt, bus_3.a_out);
        end
    endtask

`ifdef COMP_SWEEP_ABORT_EN
    task automatic test_abort();
        logic [16:0] exp;
        int stop_at [2];
        stop_at[0] = 3;
        stop_at[1] = 7;
        for (int k = 0; k < 2; k++) begin
            bus.start = 1'b1;
            tick();
            bus.start = 1'b0;
            for (int i = 0; i < stop_at[k]; i++) tick();
            bus.abort = 1'b1;
            tick();
            bus.abort = 1'b0;
            exp = mk(0, 0, 4'(stop_at[k]), exp_cnt(stop_at[k]) > 0,
                     4'(exp_first(stop_at[k])), 5'(exp_cnt(stop_at[k])));
            n_checks++;
            if (obs !== exp) begin
                n_fail++; $display("FAIL abort_at_%0d got=%h exp=%h", stop_at[k], obs, exp);
            end
            tick();
            n_checks++;
            if (obs !== exp) begin
                n_fail++; $display("FAIL abort_hold_%0d got=%h exp=%h", stop_at[k], obs, exp);
            end
        end
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        n_checks++;
        if (obs !== exp) begin
            n_fail++; $display("FAIL abort_idle_ignored got=%h exp=%h", obs, exp);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_default_sweep();
        test_back_to_back();
        test_reset_mid();
        test_random();
        test_alt_params();
`ifdef COMP_SWEEP_ABORT_EN
        test_abort();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout after %0d checks", n_checks);
        $fatal(1, "watchdog");
    end

endmodule
